// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Purpose  : Assembles a UART byte stream (big-endian header N + N words) into
//            32-bit instruction-memory writes from word address 0.
// Revision : 1.0
// ============================================================================
module instruction_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_WORDS  = 65536
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  reload_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] wa_o,
    output logic [31:0]           wd_o,
    output logic                  done_o,
    output logic                  error_o
);

    typedef enum logic [1:0] {
        S_HEADER = 2'd0,
        S_DATA   = 2'd1,
        S_DONE   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    localparam logic [32:0] C_MEM_WORDS = 33'(MEM_WORDS);

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [31:0]           n_q, n_d;
    logic [23:0]           asm_q, asm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [31:0]           wd_q, wd_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [31:0]           n_shift_w;
    logic [31:0]           word_w;
    logic [ADDR_WIDTH:0]   cnt_inc_w;
    logic                  last_byte_w;

    // Only three bytes need storage: the fourth arrives on the write cycle itself.
    assign n_shift_w   = {n_q[23:0], rx_data_i};
    assign word_w      = {asm_q, rx_data_i};
    assign cnt_inc_w   = cnt_q + (ADDR_WIDTH+1)'(1);
    assign last_byte_w = (byte_idx_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        done_d     = done_q;
        error_d    = error_q;

        if (reload_i) begin
            state_d    = S_HEADER;
            byte_idx_d = 2'd0;
            cnt_d      = '0;
            n_d        = '0;
            asm_d      = '0;
            wa_d       = '0;
            wd_d       = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
        end else begin
            case (state_q)
                S_HEADER: begin
                    if (rx_valid_i) begin
                        n_d        = n_shift_w;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (last_byte_w) begin
                            if (n_shift_w == 32'd0) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end else if ({1'b0, n_shift_w} > C_MEM_WORDS) begin
                                state_d = S_ERROR;
                                error_d = 1'b1;
                            end else begin
                                state_d = S_DATA;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        asm_d      = {asm_q[15:0], rx_data_i};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (last_byte_w) begin
                            we_d  = 1'b1;
                            wd_d  = word_w;
                            wa_d  = cnt_q[ADDR_WIDTH-1:0];
                            cnt_d = cnt_inc_w;
                            if (32'(cnt_inc_w) == n_q) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                end
                S_ERROR: begin
                    error_d = 1'b1;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = S_HEADER;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_HEADER;
            byte_idx_q <= 2'd0;
            cnt_q      <= '0;
            n_q        <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign we_o    = we_q;
    assign wa_o    = wa_q;
    assign wd_o    = wd_q;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule
`default_nettype wire
